ru_wb_sched: RTL and testbench
==============================

// Module: ru_wb_sched
// PURPOSE
//  Writeback scheduler for the single register-unit (RU) write port in rv32i_mono.
//  Shares the port between two sources:
//   - the core writeback (DataWr from the RUDataWrSrc mux),
//   - variable-latency data-memory load returns.
//  A per-register busy scoreboard raises Stall on RAW/WAW hazards against loads still in flight.
// PARAMETERS
//  LQ_DEPTH   4   outstanding-load queue depth (power of 2, >=2); holds destination rd
//  WB_DEPTH   2   buffered load-return entries {rd,data} (power of 2, >=2)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous active-low reset
//  CoreWrEn     in   1   core writes CoreRd this cycle (ALU/PC result)
//  CoreRd       in   5   core destination register
//  CoreDataWr   in   32  core write data (DataWr)
//  LoadIssue    in   1   core issues a load to data memory this cycle
//  LoadRd       in   5   destination register of the issued load
//  Rs1          in   5   source register 1 of current instruction
//  Rs1Used      in   1   Rs1 is actually read
//  Rs2          in   5   source register 2 of current instruction
//  Rs2Used      in   1   Rs2 is actually read
//  MemRspValid  in   1   load data returning (in issue order)
//  MemRspData   in   32  returned load data
//  MemRspReady  out  1   write buffer can accept a response
//  RUWr         out  1   RU write enable
//  RUAddr       out  5   RU write address
//  RUDataWr     out  32  RU write data
//  Stall        out  1   core must hold current instruction
//  LoadQFull    out  1   LQ holds LQ_DEPTH entries
//  RspErr       out  1   sticky: response arrived with LQ empty
// BEHAVIOUR
//  Reset: while rst_n=0 at a clk edge, the block clears:
//   - LQ and WB (both empty),
//   - Busy[31:0]=0,
//   - RspErr=0.
//  Output forcing: combinational outputs RUWr, Stall and MemRspReady read 0 while rst_n=0.
//   This covers reset asserted mid-operation; pending loads are dropped.
//  Stall is combinational, from registered Busy only (no same-cycle bypass):
//   (Rs1Used&Busy[Rs1]) | (Rs2Used&Busy[Rs2]) | (CoreWrEn&Busy[CoreRd])
//   | (LoadIssue&(LoadQFull|Busy[LoadRd])).
//  While Stall=1, CoreWrEn and LoadIssue are ignored internally.
//  Load issue (accepted, not stalled):
//   - push LoadRd into LQ;
//   - set Busy[LoadRd] at the next edge, unless LoadRd=0.
//  Response acceptance:
//   - MemRspReady = !WB full;
//   - accept = MemRspValid & MemRspReady & LQ non-empty;
//   - pop LQ head rd, push {rd,MemRspData} into WB.
//  Orphan response: MemRspValid & MemRspReady with LQ empty -> response dropped, RspErr<=1.
//  Port arbitration is combinational with zero latency. Priority:
//   - accepted CoreWrEn with CoreRd!=0 -> core wins: RUAddr=CoreRd, RUDataWr=CoreDataWr;
//   - else WB non-empty -> WB head drives the port; pop it at the edge.
//   - Busy[head.rd] clears at that same edge.
//   - otherwise RUWr=0.
//  x0 handling:
//   - no rd=0 write ever asserts RUWr;
//   - a WB entry with rd=0 still pops in its slot (RUWr=0).
//  Idle values: RUAddr and RUDataWr read 0 when RUWr=0.
//  Simultaneous events:
//   - WB push and pop in one cycle are both legal, also when WB is full (MemRspReady=0 stands).
//   - LQ push and pop in one cycle are legal.
//   - Busy clear and set in one cycle hit different rds, since a busy rd stalls issue.
//  Load-to-use penalty: a dependent instruction stalls until the cycle after the RU write.
//  Counters: occupancy counters are log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
// STRUCTURE
//  Package rv_wb_pkg:
//   - typedef regaddr_t (logic[4:0]);
//   - typedef wb_entry_t struct {regaddr_t rd; logic[31:0] data;};
//   - localparam REG_X0=5'd0.
//  Sub-module wb_fifo (DEPTH, type T), synchronous, sync active-low reset.
//   - Outputs: full, empty, head.
//   - Instantiated twice: LQ (T=regaddr_t) and WB (T=wb_entry_t).
//  Scoreboard and arbitration logic live in ru_wb_sched.
// TESTING
//  1. Core write only: CoreWrEn=1, CoreRd=5, CoreDataWr=DEADBEEF
//     -> same cycle RUWr=1, RUAddr=5, RUDataWr=DEADBEEF, Stall=0.
//  2. Load then return: LoadIssue, LoadRd=7; next cycle Rs1=7, Rs1Used=1 -> Stall=1.
//     MemRspData=CAFEBABE -> RU write x7 one cycle later; Stall=0 the cycle after.
//  3. Collision: WB holds {3,11111111} while CoreWrEn, CoreRd=9, data 00000010
//     -> x9 written first, x3 next cycle; Busy[3] clears after that write.
//  4. Fill: 4 LoadIssue to x1..x4 -> LoadQFull=1; a 5th LoadIssue to x6 -> Stall=1.
//     WB full with core writing every cycle -> MemRspReady=0, no data lost.
//  5. x0 / WAW: LoadRd=0 -> Busy unchanged, return gives RUWr=0.
//     CoreWrEn to a busy x7 -> Stall=1 until the x7 load retires.
//     MemRspValid with LQ empty -> RspErr=1 and stays 1.
//  6. Reset mid-operation: rst_n=0 with 2 loads pending -> next cycle LQ/WB empty,
//     Busy=0, RUWr=0, RspErr=0.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types for the register-unit writeback scheduler.
package rv_wb_pkg;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    regaddr_t    rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam regaddr_t REG_X0 = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with registered head, used for both the load queue and write buffer.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  T             mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; push into a full FIFO only lands when it also pops.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ru_wb_sched.sv
// Writeback scheduler sharing the single RU write port between core results and load returns.
module ru_wb_sched
  import rv_wb_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CoreWrEn,
  input  logic [4:0]  CoreRd,
  input  logic [31:0] CoreDataWr,
  input  logic        LoadIssue,
  input  logic [4:0]  LoadRd,
  input  logic [4:0]  Rs1,
  input  logic        Rs1Used,
  input  logic [4:0]  Rs2,
  input  logic        Rs2Used,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData,
  output logic        MemRspReady,
  output logic        RUWr,
  output logic [4:0]  RUAddr,
  output logic [31:0] RUDataWr,
  output logic        Stall,
  output logic        LoadQFull,
  output logic        RspErr
);

  logic [31:0] busy_q, busy_d;
  logic        rsp_err_q, rsp_err_d;
  logic        lq_full, lq_empty, wb_full, wb_empty;
  regaddr_t    lq_head;
  wb_entry_t   wb_head, wb_din;
  logic        core_en, load_en, core_wins;
  logic        rsp_fire, rsp_accept, wb_pop;

  // Load queue: destination registers of loads still waiting for their data.
  wb_fifo #(.DEPTH(LQ_DEPTH), .T(regaddr_t)) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (load_en),
    .pop   (rsp_accept),
    .din   (LoadRd),
    .full  (lq_full),
    .empty (lq_empty),
    .head  (lq_head)
  );

  // Write buffer: returned load data waiting for a free slot on the RU port.
  wb_fifo #(.DEPTH(WB_DEPTH), .T(wb_entry_t)) u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_accept),
    .pop   (wb_pop),
    .din   (wb_din),
    .full  (wb_full),
    .empty (wb_empty),
    .head  (wb_head)
  );

  assign LoadQFull = lq_full;
  assign RspErr    = rsp_err_q;

  // Hazard detection, port arbitration and scoreboard next-state; reset forces the port and handshakes idle.
  always_comb begin
    Stall = rst_n && ((Rs1Used && busy_q[Rs1]) || (Rs2Used && busy_q[Rs2]) ||
                      (CoreWrEn && busy_q[CoreRd]) ||
                      (LoadIssue && (lq_full || busy_q[LoadRd])));
    core_en     = rst_n && CoreWrEn && !Stall;
    load_en     = rst_n && LoadIssue && !Stall;
    MemRspReady = rst_n && !wb_full;
    rsp_fire    = MemRspValid && MemRspReady;
    rsp_accept  = rsp_fire && !lq_empty;
    wb_din      = '{rd: lq_head, data: MemRspData};
    core_wins   = core_en && (CoreRd != REG_X0);
    wb_pop      = rst_n && !core_wins && !wb_empty;

    RUWr     = 1'b0;
    RUAddr   = '0;
    RUDataWr = '0;
    if (core_wins) begin
      RUWr     = 1'b1;
      RUAddr   = CoreRd;
      RUDataWr = CoreDataWr;
    end else if (wb_pop && (wb_head.rd != REG_X0)) begin
      RUWr     = 1'b1;
      RUAddr   = wb_head.rd;
      RUDataWr = wb_head.data;
    end

    busy_d = busy_q;
    if (wb_pop) begin
      busy_d[wb_head.rd] = 1'b0;
    end
    if (load_en && (LoadRd != REG_X0)) begin
      busy_d[LoadRd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    rsp_err_d = rsp_err_q || (rsp_fire && lq_empty);
  end

  // Scoreboard and sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ru_wb_sched.sv
// Directed table-driven bench for the RU writeback scheduler.
module tb_ru_wb_sched;

  typedef struct {
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_data;
    logic        ld_iss;
    logic [4:0]  ld_rd;
    logic [4:0]  rs1;
    logic        rs1_used;
    logic [4:0]  rs2;
    logic        rs2_used;
    logic        rsp_v;
    logic [31:0] rsp_data;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_rdy;
    logic        e_lqfull;
    logic        e_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        CoreWrEn;
  logic [4:0]  CoreRd;
  logic [31:0] CoreDataWr;
  logic        LoadIssue;
  logic [4:0]  LoadRd;
  logic [4:0]  Rs1;
  logic        Rs1Used;
  logic [4:0]  Rs2;
  logic        Rs2Used;
  logic        MemRspValid;
  logic [31:0] MemRspData;
  logic        MemRspReady;
  logic        RUWr;
  logic [4:0]  RUAddr;
  logic [31:0] RUDataWr;
  logic        Stall;
  logic        LoadQFull;
  logic        RspErr;

  int checks;
  int failures;
  vec_t vecs[$];

  ru_wb_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CoreWrEn    (CoreWrEn),
    .CoreRd      (CoreRd),
    .CoreDataWr  (CoreDataWr),
    .LoadIssue   (LoadIssue),
    .LoadRd      (LoadRd),
    .Rs1         (Rs1),
    .Rs1Used     (Rs1Used),
    .Rs2         (Rs2),
    .Rs2Used     (Rs2Used),
    .MemRspValid (MemRspValid),
    .MemRspData  (MemRspData),
    .MemRspReady (MemRspReady),
    .RUWr        (RUWr),
    .RUAddr      (RUAddr),
    .RUDataWr    (RUDataWr),
    .Stall       (Stall),
    .LoadQFull   (LoadQFull),
    .RspErr      (RspErr)
  );

  // Free-running clock, rising edge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append one cycle of stimulus together with the outputs expected before that cycle's edge.
  task automatic addVec(input logic rn, input logic cw, input logic [4:0] crd, input logic [31:0] cd,
                        input logic li, input logic [4:0] lrd,
                        input logic [4:0] r1, input logic r1u, input logic [4:0] r2, input logic r2u,
                        input logic rv, input logic [31:0] rd,
                        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                        input logic es, input logic er, input logic el, input logic ee);
    vec_t v;
    v.rst_n = rn; v.core_we = cw; v.core_rd = crd; v.core_data = cd;
    v.ld_iss = li; v.ld_rd = lrd;
    v.rs1 = r1; v.rs1_used = r1u; v.rs2 = r2; v.rs2_used = r2u;
    v.rsp_v = rv; v.rsp_data = rd;
    v.e_wr = ew; v.e_addr = ea; v.e_data = ed;
    v.e_stall = es; v.e_rdy = er; v.e_lqfull = el; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Drive one vector mid-cycle, away from the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n       = v.rst_n;
    CoreWrEn    = v.core_we;
    CoreRd      = v.core_rd;
    CoreDataWr  = v.core_data;
    LoadIssue   = v.ld_iss;
    LoadRd      = v.ld_rd;
    Rs1         = v.rs1;
    Rs1Used     = v.rs1_used;
    Rs2         = v.rs2;
    Rs2Used     = v.rs2_used;
    MemRspValid = v.rsp_v;
    MemRspData  = v.rsp_data;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp("RUWr",        idx, 32'(RUWr),        32'(v.e_wr));
    cmp("RUAddr",      idx, 32'(RUAddr),      32'(v.e_addr));
    cmp("RUDataWr",    idx, RUDataWr,         v.e_data);
    cmp("Stall",       idx, 32'(Stall),       32'(v.e_stall));
    cmp("MemRspReady", idx, 32'(MemRspReady), 32'(v.e_rdy));
    cmp("LoadQFull",   idx, 32'(LoadQFull),   32'(v.e_lqfull));
    cmp("RspErr",      idx, 32'(RspErr),      32'(v.e_err));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; CoreWrEn = 1'b0; CoreRd = '0; CoreDataWr = '0;
    LoadIssue = 1'b0; LoadRd = '0; Rs1 = '0; Rs1Used = 1'b0; Rs2 = '0; Rs2Used = 1'b0;
    MemRspValid = 1'b0; MemRspData = '0;
    repeat (2) @(posedge clk);

    // Reset forcing: activity on inputs must not reach the port or handshakes.
    addVec(0, 1,5,32'h1234, 0,0, 0,0,0,0, 1,32'h1, 0,0,0, 0,0,0,0);
    // Core write only.
    addVec(1, 1,5,32'hDEADBEEF, 0,0, 0,0,0,0, 0,0, 1,5,32'hDEADBEEF, 0,1,0,0);
    // Load x7, dependent read stalls, data returns and retires.
    addVec(1, 0,0,0, 1,7, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 7,1,0,0, 1,32'hCAFEBABE, 0,0,0, 1,1,0,0);
    addVec(1, 0,0,0, 0,0, 7,1,0,0, 0,0, 1,7,32'hCAFEBABE, 1,1,0,0);
    addVec(1, 0,0,0, 0,0, 7,1,0,0, 0,0, 0,0,0, 0,1,0,0);
    // Collision: buffered x3 waits behind a core write to x9.
    addVec(1, 0,0,0, 1,3, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'h11111111, 0,0,0, 0,1,0,0);
    addVec(1, 1,9,32'h00000010, 0,0, 0,0,0,0, 0,0, 1,9,32'h00000010, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,3,1, 0,0, 1,3,32'h11111111, 1,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,3,1, 0,0, 0,0,0, 0,1,0,0);
    // Fill the load queue, then a fifth load stalls.
    addVec(1, 0,0,0, 1,1, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 1,2, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 1,3, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 1,4, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 1,6, 0,0,0,0, 0,0, 0,0,0, 1,1,1,0);
    // Core keeps the port busy while responses fill the write buffer.
    addVec(1, 1,10,32'h100, 0,0, 0,0,0,0, 1,32'hA1, 1,10,32'h100, 0,1,1,0);
    addVec(1, 1,11,32'h101, 0,0, 0,0,0,0, 1,32'hA2, 1,11,32'h101, 0,1,0,0);
    addVec(1, 1,12,32'h102, 0,0, 0,0,0,0, 1,32'hA3, 1,12,32'h102, 0,0,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'hA3, 1,1,32'hA1, 0,0,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'hA3, 1,2,32'hA2, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'hA4, 1,3,32'hA3, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 0,0, 1,4,32'hA4, 0,1,0,0);
    // Load to x0 never marks busy and its return never writes.
    addVec(1, 0,0,0, 1,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,1,0,0, 1,32'h55, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    // WAW: core write to x7 waits until the outstanding x7 load retires.
    addVec(1, 0,0,0, 1,7, 0,0,0,0, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 1,7,32'h77, 0,0, 0,0,0,0, 0,0, 0,0,0, 1,1,0,0);
    addVec(1, 1,7,32'h77, 0,0, 0,0,0,0, 1,32'h700, 0,0,0, 1,1,0,0);
    addVec(1, 1,7,32'h77, 0,0, 0,0,0,0, 0,0, 1,7,32'h700, 1,1,0,0);
    addVec(1, 1,7,32'h77, 0,0, 0,0,0,0, 0,0, 1,7,32'h77, 0,1,0,0);
    // Orphan response sets the sticky error.
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'hBAD, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0,1);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0,1);
    // Reset with two loads pending.
    addVec(1, 0,0,0, 1,8, 0,0,0,0, 0,0, 0,0,0, 0,1,0,1);
    addVec(1, 0,0,0, 1,9, 0,0,0,0, 0,0, 0,0,0, 0,1,0,1);
    addVec(0, 0,0,0, 0,0, 8,1,0,0, 1,32'h1, 0,0,0, 0,0,0,1);
    addVec(1, 0,0,0, 0,0, 8,1,9,1, 0,0, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 1,32'h2, 0,0,0, 0,1,0,0);
    addVec(1, 0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0,1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
